// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: register address type,
// sequencer states, the per-stage control bundle and the rule that won
// arbitration in a given cycle.
package pipeline_ctrl_pkg;

  typedef logic [4:0] creg_addr_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    IDROP = 2'd2
  } ctrl_state_t;

  // Highest-priority condition active in the current cycle
  typedef enum logic [2:0] {
    RULE_RESET  = 3'd0,
    RULE_DWAIT  = 3'd1,
    RULE_IDROP  = 3'd2,
    RULE_BRANCH = 3'd3,
    RULE_LUSE   = 3'd4,
    RULE_ISTALL = 3'd5,
    RULE_RUN    = 3'd6
  } rule_t;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_m;
    logic en_w;
    logic flush_d;
    logic bubble_e;
  } stage_ctl_t;

  // True when a non-zero destination feeds either source register
  function automatic logic reg_conflict(input creg_addr_t rd,
                                        input creg_addr_t rs,
                                        input creg_addr_t rt);
    return (rd != 5'd0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in E whose destination is read by the
// instruction in D forces a one-cycle stall.
module hazard_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic       ex_valid,
  input  logic       de_valid,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_rd,
  input  logic [4:0] de_rs,
  input  logic [4:0] de_rt,
  output logic       load_use
);

  assign load_use = ex_valid & de_valid & ex_mem_to_reg &
                    reg_conflict(ex_rd, de_rs, de_rt);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage F/D/E/M/W pipeline. Produces stage
// load enables and NOP-insert strobes from bus-wait, load-use and branch
// conditions; an FSM drops wrong-path fetches and watches dbus waits.
// Optional build macro PIPE_PERF_CNT_EN adds performance counter outputs.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int PERF_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_busy,
  input  logic       d_busy,
  input  logic       de_valid,
  input  logic [4:0] de_rs,
  input  logic [4:0] de_rt,
  input  logic       ex_valid,
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_rd,
  input  logic       ex_branch_taken,
  output logic       en_f,
  output logic       en_d,
  output logic       en_e,
  output logic       en_m,
  output logic       en_w,
  output logic       flush_d,
  output logic       bubble_e,
  output logic       pc_redirect,
  output logic       fetch_discard,
  output logic       timeout_err
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_cycles,
  output logic [PERF_W-1:0] perf_dstall,
  output logic [PERF_W-1:0] perf_istall,
  output logic [PERF_W-1:0] perf_luse,
  output logic [PERF_W-1:0] perf_flush
`endif
);

  localparam logic [TIMEOUT_W-1:0] WD_LIMIT = {TIMEOUT_W{1'b1}};

  ctrl_state_t           state_r;
  ctrl_state_t           state_next_s;
  rule_t                 rule_s;
  stage_ctl_t            ctl_s;
  logic                  pc_redirect_s;
  logic                  fetch_discard_s;
  logic                  load_use_s;
  logic [TIMEOUT_W-1:0]  wd_cnt_r;
  logic                  timeout_err_r;

  hazard_detect u_hazard_detect (
    .ex_valid      (ex_valid),
    .de_valid      (de_valid),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_rd         (ex_rd),
    .de_rs         (de_rs),
    .de_rt         (de_rt),
    .load_use      (load_use_s)
  );

  // Pick the highest-priority condition active this cycle
  always_comb begin
    rule_s = RULE_RUN;
    if (reset) begin
      rule_s = RULE_RESET;
    end else if (d_busy) begin
      rule_s = RULE_DWAIT;
    end else if (state_r == IDROP) begin
      rule_s = RULE_IDROP;
    end else if (ex_branch_taken) begin
      rule_s = RULE_BRANCH;
    end else if (load_use_s) begin
      rule_s = RULE_LUSE;
    end else if (i_busy) begin
      rule_s = RULE_ISTALL;
    end else begin
      rule_s = RULE_RUN;
    end
  end

  // Stage controls and next state for the selected rule
  always_comb begin
    ctl_s           = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_m: 1'b0,
                        en_w: 1'b0, flush_d: 1'b0, bubble_e: 1'b0};
    pc_redirect_s   = 1'b0;
    fetch_discard_s = 1'b0;
    state_next_s    = RUN;
    case (rule_s)
      RULE_RESET: begin
        state_next_s = RUN;
      end
      RULE_DWAIT: begin
        // Everything frozen; a taken branch stays parked in E
        state_next_s = DWAIT;
      end
      RULE_IDROP: begin
        ctl_s           = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b1, en_m: 1'b1,
                            en_w: 1'b1, flush_d: 1'b0, bubble_e: 1'b1};
        fetch_discard_s = 1'b1;
        state_next_s    = i_busy ? IDROP : RUN;
      end
      RULE_BRANCH: begin
        ctl_s           = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1,
                            en_w: 1'b1, flush_d: 1'b1, bubble_e: 1'b1};
        pc_redirect_s   = 1'b1;
        // An in-flight fetch belongs to the wrong path; drop it on return
        fetch_discard_s = i_busy;
        state_next_s    = i_busy ? IDROP : RUN;
      end
      RULE_LUSE, RULE_ISTALL: begin
        ctl_s = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b1, en_m: 1'b1,
                  en_w: 1'b1, flush_d: 1'b0, bubble_e: 1'b1};
      end
      RULE_RUN: begin
        ctl_s = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_m: 1'b1,
                  en_w: 1'b1, flush_d: 1'b0, bubble_e: 1'b0};
      end
      default: begin
        state_next_s = RUN;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Dbus-wait watchdog: counts consecutive busy cycles, flags a sticky error
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_r      <= {TIMEOUT_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else if (d_busy) begin
      if (wd_cnt_r != WD_LIMIT) begin
        wd_cnt_r <= wd_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (wd_cnt_r >= (WD_LIMIT - {{(TIMEOUT_W-1){1'b0}}, 1'b1})) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end else begin
      wd_cnt_r      <= {TIMEOUT_W{1'b0}};
      timeout_err_r <= timeout_err_r;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};

  logic [PERF_W-1:0] perf_cycles_r;
  logic [PERF_W-1:0] perf_dstall_r;
  logic [PERF_W-1:0] perf_istall_r;
  logic [PERF_W-1:0] perf_luse_r;
  logic [PERF_W-1:0] perf_flush_r;

  // Wrapping event counters, one per stall/flush cause plus total cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_cycles_r <= {PERF_W{1'b0}};
      perf_dstall_r <= {PERF_W{1'b0}};
      perf_istall_r <= {PERF_W{1'b0}};
      perf_luse_r   <= {PERF_W{1'b0}};
      perf_flush_r  <= {PERF_W{1'b0}};
    end else begin
      perf_cycles_r <= perf_cycles_r + PERF_ONE;
      perf_dstall_r <= perf_dstall_r + ((rule_s == RULE_DWAIT)  ? PERF_ONE : {PERF_W{1'b0}});
      perf_istall_r <= perf_istall_r + ((rule_s == RULE_ISTALL) ? PERF_ONE : {PERF_W{1'b0}});
      perf_luse_r   <= perf_luse_r   + ((rule_s == RULE_LUSE)   ? PERF_ONE : {PERF_W{1'b0}});
      perf_flush_r  <= perf_flush_r  + ((rule_s == RULE_BRANCH) ? PERF_ONE : {PERF_W{1'b0}});
    end
  end

  assign perf_cycles = perf_cycles_r;
  assign perf_dstall = perf_dstall_r;
  assign perf_istall = perf_istall_r;
  assign perf_luse   = perf_luse_r;
  assign perf_flush  = perf_flush_r;
`endif

  assign en_f          = ctl_s.en_f;
  assign en_d          = ctl_s.en_d;
  assign en_e          = ctl_s.en_e;
  assign en_m          = ctl_s.en_m;
  assign en_w          = ctl_s.en_w;
  assign flush_d       = ctl_s.flush_d;
  assign bubble_e      = ctl_s.bubble_e;
  assign pc_redirect   = pc_redirect_s;
  assign fetch_discard = fetch_discard_s;
  assign timeout_err   = timeout_err_r;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int TW    = 3;
  localparam int LIMIT = (1 << TW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, i_busy, d_busy, de_valid, ex_valid, ex_mem_to_reg, ex_branch_taken;
  logic [4:0] de_rs, de_rt, ex_rd;
  logic       en_f, en_d, en_e, en_m, en_w, flush_d, bubble_e;
  logic       pc_redirect, fetch_discard, timeout_err;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_cycles, perf_dstall, perf_istall, perf_luse, perf_flush;
`endif

  pipeline_ctrl #(.TIMEOUT_W(TW), .PERF_W(32)) dut (
    .clk(clk), .reset(reset), .i_busy(i_busy), .d_busy(d_busy),
    .de_valid(de_valid), .de_rs(de_rs), .de_rt(de_rt),
    .ex_valid(ex_valid), .ex_mem_to_reg(ex_mem_to_reg), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken),
    .en_f(en_f), .en_d(en_d), .en_e(en_e), .en_m(en_m), .en_w(en_w),
    .flush_d(flush_d), .bubble_e(bubble_e), .pc_redirect(pc_redirect),
    .fetch_discard(fetch_discard), .timeout_err(timeout_err)
`ifdef PIPE_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_dstall(perf_dstall), .perf_istall(perf_istall),
    .perf_luse(perf_luse), .perf_flush(perf_flush)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: wrong-path fetch pending, length of current dbus wait,
  // sticky timeout, and per-cause event counts.
  bit m_drop = 1'b0;
  int m_wait = 0;
  bit m_err  = 1'b0;
  int m_cyc = 0, m_dst = 0, m_ist = 0, m_lu = 0, m_fl = 0;

  // Outputs observed in the most recent step (for directed spot checks)
  logic [4:0] last_en;
  logic       last_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    reset = 1'b0; i_busy = 1'b0; d_busy = 1'b0; de_valid = 1'b0; ex_valid = 1'b0;
    ex_mem_to_reg = 1'b0; ex_branch_taken = 1'b0; de_rs = 5'd0; de_rt = 5'd0; ex_rd = 5'd0;
  endtask

  // Inputs have been set just after a negedge; check outputs, then advance model
  task automatic step();
    logic [4:0] e_en;
    logic e_fl, e_bu, e_pr, e_fd, lu;
    #1;
    lu = ex_valid && de_valid && ex_mem_to_reg && (ex_rd != 5'd0) &&
         ((ex_rd == de_rs) || (ex_rd == de_rt));
    e_en = 5'b00000; e_fl = 1'b0; e_bu = 1'b0; e_pr = 1'b0; e_fd = 1'b0;
    if (reset || d_busy) begin
      e_en = 5'b00000;
    end else if (m_drop) begin
      e_en = 5'b00111; e_bu = 1'b1; e_fd = 1'b1;
    end else if (ex_branch_taken) begin
      e_en = 5'b11111; e_fl = 1'b1; e_bu = 1'b1; e_pr = 1'b1; e_fd = i_busy;
    end else if (lu || i_busy) begin
      e_en = 5'b00111; e_bu = 1'b1;
    end else begin
      e_en = 5'b11111;
    end
    last_en = {en_f, en_d, en_e, en_m, en_w};
    last_fd = fetch_discard;
    chk("en_fdemw", {27'd0, last_en}, {27'd0, e_en});
    chk("flush_d", {31'd0, flush_d}, {31'd0, e_fl});
    chk("bubble_e", {31'd0, bubble_e}, {31'd0, e_bu});
    chk("pc_redirect", {31'd0, pc_redirect}, {31'd0, e_pr});
    chk("fetch_discard", {31'd0, fetch_discard}, {31'd0, e_fd});
    chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
`ifdef PIPE_PERF_CNT_EN
    chk("perf_cycles", perf_cycles, m_cyc);
    chk("perf_dstall", perf_dstall, m_dst);
    chk("perf_istall", perf_istall, m_ist);
    chk("perf_luse", perf_luse, m_lu);
    chk("perf_flush", perf_flush, m_fl);
`endif
    if (reset) begin
      m_drop = 1'b0; m_wait = 0; m_err = 1'b0;
      m_cyc = 0; m_dst = 0; m_ist = 0; m_lu = 0; m_fl = 0;
    end else begin
      m_cyc++;
      if (d_busy) begin
        m_dst++;
        m_wait = (m_wait < LIMIT) ? m_wait + 1 : LIMIT;
        if (m_wait >= LIMIT) m_err = 1'b1;
        m_drop = 1'b0;
      end else begin
        m_wait = 0;
        if (m_drop) begin
          m_drop = i_busy;
        end else if (ex_branch_taken) begin
          m_fl++;
          m_drop = i_busy;
        end else if (lu) begin
          m_lu++;
        end else if (i_busy) begin
          m_ist++;
        end
      end
    end
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    int fd_cnt;
    idle_inputs();
    // Reset held for two cycles, then idle: full flow on the first cycle
    reset = 1'b1; next_cycle(); step(); next_cycle(); step();
    chk("reset_en", {27'd0, last_en}, 32'd0);
    reset = 1'b0; next_cycle(); step();
    chk("post_reset_en", {27'd0, last_en}, 32'h1f);

    // Load-use on rs, then same with destination r0 (no hazard)
    next_cycle(); ex_valid = 1'b1; de_valid = 1'b1; ex_mem_to_reg = 1'b1;
    ex_rd = 5'd8; de_rs = 5'd8; de_rt = 5'd3; step();
    chk("luse_stall", {27'd0, last_en}, 32'h07);
    next_cycle(); ex_rd = 5'd0; de_rs = 5'd0; step();
    chk("luse_r0", {27'd0, last_en}, 32'h1f);
    next_cycle(); idle_inputs(); step();

    // Dbus wait with a taken branch parked in E; redirect on release
    ex_branch_taken = 1'b1; d_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin next_cycle(); step(); end
    next_cycle(); d_busy = 1'b0; step();
    chk("branch_after_dwait", {31'd0, pc_redirect}, 32'd1);
    next_cycle(); idle_inputs(); step();

    // Taken branch while a fetch is outstanding: wrong-path data dropped
    fd_cnt = 0;
    next_cycle(); ex_branch_taken = 1'b1; i_busy = 1'b1; step(); fd_cnt += int'(last_fd);
    next_cycle(); ex_branch_taken = 1'b0; step(); fd_cnt += int'(last_fd);
    next_cycle(); i_busy = 1'b0; step(); fd_cnt += int'(last_fd);
    next_cycle(); step(); fd_cnt += int'(last_fd);
    chk("discard_cycles", fd_cnt, 32'd3);

    // Watchdog: ten busy cycles, error after the seventh, sticky afterwards
    next_cycle(); reset = 1'b1; step();
    next_cycle(); reset = 1'b0; d_busy = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 7) chk("timeout_before", {31'd0, timeout_err}, 32'd0);
      if (i == 8) chk("timeout_after", {31'd0, timeout_err}, 32'd1);
      next_cycle();
    end
    d_busy = 1'b0; step();
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);

    // Random traffic
    next_cycle(); reset = 1'b1; step();
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      reset           = ($urandom_range(0, 99) < 2);
      d_busy          = ($urandom_range(0, 99) < 15);
      i_busy          = ($urandom_range(0, 99) < 35);
      ex_branch_taken = ($urandom_range(0, 99) < 15);
      ex_valid        = ($urandom_range(0, 99) < 80);
      de_valid        = ($urandom_range(0, 99) < 80);
      ex_mem_to_reg   = ($urandom_range(0, 99) < 50);
      ex_rd           = 5'($urandom_range(0, 3));
      de_rs           = 5'($urandom_range(0, 3));
      de_rt           = 5'($urandom_range(0, 3));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
